decrypted_word_packer: RTL
==========================

Name: decrypted_word_packer

Overview:
- Downstream stage of the decryption top level, in the clk_sys domain.
- Consumes the 8-bit decrypted character stream (data/valid from the output mux).
- Packs characters into 32-bit words, closes a message on the terminator byte, and buffers packed words in a small FIFO.
- Words leave through a valid/ready handshake towards the system bus side.

Parameters:
- SYS_DWIDTH, 8, width of one decrypted character.
- MST_DWIDTH, 32, width of a packed word; must equal 4*SYS_DWIDTH.
- FIFO_DEPTH, 4, number of packed words buffered; power of two, minimum 2.
- TERMINATOR, 8'hFA, end-of-message character value.

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_i  in  SYS_DWIDTH  decrypted character.
- valid_i  in  1  data_i is valid this cycle. No backpressure: every valid character is taken.
- data_o  out  MST_DWIDTH  packed word at the FIFO head.
- keep_o  out  4  byte-valid mask for data_o; bit 3 marks byte [31:24].
- last_o  out  1  data_o is the final word of a message.
- valid_o  out  1  the FIFO head is valid.
- ready_i  in  1  downstream accepts data_o this cycle.
- fifo_level  out  clog2(FIFO_DEPTH+1)  number of words stored.
- overflow  out  1  sticky flag: a word was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, any time, including mid-word or mid-transfer): pack register cleared, byte count = 0, FIFO emptied.
  - Output values while reset is asserted: data_o=0, keep_o=0, last_o=0, valid_o=0, fifo_level=0, overflow=0.
- Packing FSM has two states:
  - IDLE: byte count 0.
  - ACC: 1-3 bytes held.
- Character placement: the first character of a word goes to [31:24], then [23:16], [15:8], [7:0] (character order MSB first).
- A non-terminator character arriving as the 4th byte completes the word:
  - push {word, keep=1111, last=0}; byte count returns to 0; FSM goes to IDLE.
- A character equal to TERMINATOR is never stored in a word. It closes the current word:
  - unused low bytes are zero-padded;
  - keep_o has one bit set per byte held, counted from bit 3 down;
  - last=1; push the word; return to IDLE.
- Terminator in IDLE (0 bytes held, including right after a full word): push {0, keep=0000, last=1}, so end-of-message is always signalled.
- The push happens on the clock edge of the completing character. valid_o rises on that same edge when the FIFO was empty, i.e. visible in the cycle after the character (latency 1).
- FIFO:
  - first-word-fall-through: data_o, keep_o and last_o always show the head entry;
  - valid_o = (fifo_level != 0);
  - a pop occurs when valid_o && ready_i;
  - pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop:
  - level unchanged;
  - if the FIFO is full, the pop frees the slot and the push is accepted (no overflow).
- Push while full without a pop: the word is dropped, overflow is set to 1 and stays 1 until rst, and FIFO contents are unchanged. Character packing continues regardless.
- ready_i while empty: no effect.
- The head entry stays stable while valid_o=1 and ready_i=0.
- valid_i=0 cycles inside a word are allowed and the partial word is held indefinitely.

Test Plan:
1. Send 0x41,0x42,0x43,0x44 on consecutive cycles with ready_i=1 -> cycle after 0x44: data_o=0x41424344, keep_o=1111, last_o=0, valid_o=1 for exactly one cycle.
2. Send 0x41, (idle 3 cycles), 0x42, 0xFA -> data_o=0x41420000, keep_o=1100, last_o=1.
3. Send 0xFA alone, then 4 bytes followed by 0xFA -> first word keep_o=0000 last_o=1; second word keep=1111 last=0; third word keep=0000 last=1.
4. Hold ready_i=0 and push 5 full words with FIFO_DEPTH=4 -> fifo_level=4, overflow=1 after the 5th push; after releasing ready_i, the first 4 words drain in order and the 5th never appears.
5. With the FIFO full and ready_i=1, complete a new word in the same cycle as a pop -> fifo_level stays 4, overflow stays 0, the new word appears last in order.
6. Assert rst asynchronously after 2 bytes of a word and with 2 words queued -> all outputs 0 immediately; after release, 4 new bytes produce a single word with the new bytes only.

Source files
------------

// File: rtl/decrypted_word_packer.sv
// Packs the decrypted character stream MSB-first into 32-bit words, closing a message on TERMINATOR.
// Latency: a completed word is visible on data_o/valid_o one cycle after its completing character.
// Backpressure: none on the input side; a word arriving with the FIFO full and no pop is dropped and overflow is latched.
module decrypted_word_packer #(
  parameter int                    SYS_DWIDTH = 8,
  parameter int                    MST_DWIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [SYS_DWIDTH-1:0] TERMINATOR = 8'hFA
) (
  input  logic                               clk_sys,
  input  logic                               rst,
  input  logic [SYS_DWIDTH-1:0]              data_i,
  input  logic                               valid_i,
  output logic [MST_DWIDTH-1:0]              data_o,
  output logic [3:0]                         keep_o,
  output logic                               last_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [LVL_W-1:0] LVL_ONE  = 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  // One FIFO entry: packed word plus its byte mask and end-of-message marker.
  typedef struct packed {
    logic [MST_DWIDTH-1:0] dat;
    logic [3:0]            keep;
    logic                  last;
  } word_t;

  // Packing state
  logic [0:0]            state;
  logic [0:0]            state_nxt;
  logic [1:0]            byte_cnt;
  logic [1:0]            byte_cnt_nxt;
  logic [MST_DWIDTH-1:0] pack_reg;
  logic [MST_DWIDTH-1:0] pack_nxt;
  logic [MST_DWIDTH-1:0] placed;
  logic                  is_term;
  int                    slot_lsb;

  // Word handed to the FIFO
  logic                  push_vld;
  word_t                 push_dat;

  // FIFO state
  word_t                 mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  full;
  logic                  pop;
  logic                  wr_en;
  logic                  drop;
  word_t                 head;

  // Packing decision: place the character, or close the word on a 4th byte / terminator.
  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    pack_nxt     = pack_reg;
    push_vld     = 1'b0;
    push_dat     = '0;
    is_term      = (data_i == TERMINATOR);
    slot_lsb     = (3 - int'(byte_cnt)) * SYS_DWIDTH;
    placed       = pack_reg;
    placed[slot_lsb +: SYS_DWIDTH] = data_i;

    if (valid_i) begin
      if (is_term) begin
        // Unused low bytes are already zero because pack_reg is cleared on every push.
        push_vld      = 1'b1;
        push_dat.dat  = pack_reg;
        push_dat.last = 1'b1;
        if (state == ST_IDLE) begin
          push_dat.keep = 4'b0000;
        end else begin
          case (byte_cnt)
            2'd1:    push_dat.keep = 4'b1000;
            2'd2:    push_dat.keep = 4'b1100;
            default: push_dat.keep = 4'b1110;
          endcase
        end
        pack_nxt     = '0;
        byte_cnt_nxt = 2'd0;
        state_nxt    = ST_IDLE;
      end else if (byte_cnt == 2'd3) begin
        push_vld      = 1'b1;
        push_dat.dat  = placed;
        push_dat.keep = 4'b1111;
        push_dat.last = 1'b0;
        pack_nxt      = '0;
        byte_cnt_nxt  = 2'd0;
        state_nxt     = ST_IDLE;
      end else begin
        pack_nxt     = placed;
        byte_cnt_nxt = byte_cnt + 2'd1;
        state_nxt    = ST_ACC;
      end
    end
  end

  // Packing registers; a partial word is held across idle input cycles.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      byte_cnt <= 2'd0;
      pack_reg <= '0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      pack_reg <= pack_nxt;
    end
  end

  // A pop frees the head slot in the same cycle, so a full FIFO can still accept a push alongside it.
  always_comb begin
    full  = (level == LVL_FULL);
    pop   = (level != '0) && ready_i;
    wr_en = push_vld && (!full || pop);
    drop  = push_vld && full && !pop;
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_en && !pop) begin
        level <= level + LVL_ONE;
      end else if (pop && !wr_en) begin
        level <= level - LVL_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage array; contents beyond the occupied range are never observed, so no reset is needed.
  always_ff @(posedge clk_sys) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // First-word-fall-through head, forced to zero while empty so reset shows all-zero outputs.
  always_comb begin
    head       = mem[rd_ptr];
    valid_o    = (level != '0);
    data_o     = valid_o ? head.dat  : '0;
    keep_o     = valid_o ? head.keep : 4'b0000;
    last_o     = valid_o ? head.last : 1'b0;
    fifo_level = level;
  end

endmodule
